// File: rtl/hdc_pkg.sv
// hdc_pkg: shared FP16 constants and scheduler state encoding for the HDC classifier
package hdc_pkg;
  localparam int FP16_W = 16;
  localparam logic [FP16_W-1:0] FP16_POS_ZERO = 16'h0000;
  localparam logic [FP16_W-1:0] FP16_POS_INF  = 16'h7C00;
  localparam logic [FP16_W-1:0] FP16_NEG_INF  = 16'hFC00;
  localparam logic [FP16_W-1:0] FP16_NAN      = 16'h7E00;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} sched_state_t;
endpackage

// File: rtl/hdc_fp16_cmp.sv
// hdc_fp16_cmp: FP16 strict greater-than with NaN detection, +0 and -0 compare equal
module hdc_fp16_cmp
  import hdc_pkg::*;
(
  input  logic [FP16_W-1:0] a,
  input  logic [FP16_W-1:0] b,
  output logic              a_gt_b,
  output logic              a_is_nan
);
  logic              b_is_nan;
  logic [FP16_W-1:0] ka, kb;
  // Map each value to an unsigned key whose integer order is the float order
  always_comb begin
    a_is_nan = (a[14:10] == FP16_POS_INF[14:10]) && |a[9:0];
    b_is_nan = (b[14:10] == FP16_POS_INF[14:10]) && |b[9:0];
    ka = a[15] ? ~a : a | 16'h8000;
    kb = b[15] ? ~b : b | 16'h8000;
    a_gt_b = !a_is_nan && !b_is_nan && |{a[14:0], b[14:0]} && ka > kb;
  end
endmodule

// File: rtl/hdc_class_scheduler.sv
// hdc_class_scheduler: issues class-memory reads, tracks them through the adder tree and keeps the FP16 argmax
module hdc_class_scheduler
  import hdc_pkg::*;
#(
  parameter int  WIDTH       = FP16_W,
  parameter int  NUM_CLASSES = 16,
  parameter int  TREE_LAT    = 5,
  localparam int CLS_W       = $clog2(NUM_CLASSES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CLS_W:0]   num_classes,
  output logic             mem_rd_en,
  output logic [CLS_W-1:0] mem_addr,
  input  logic [WIDTH-1:0] tree_sum,
  output logic             busy,
  output logic             done,
  output logic [CLS_W-1:0] out_class,
  output logic [WIDTH-1:0] out_score,
  output logic             no_result
);
  localparam logic [CLS_W:0] MAX_C = (CLS_W+1)'(NUM_CLASSES);
  sched_state_t                 state, state_nx;
  logic [CLS_W:0]               num_q, num_eff, cnt;
  logic [TREE_LAT:0]            sr_vld, sr_use;
  logic [TREE_LAT:0][CLS_W-1:0] sr_tag;
  logic                         seen, fin, gt, nan, take, empty, last;
  assign num_eff   = num_classes > MAX_C ? MAX_C : num_classes;
  assign last      = cnt + (CLS_W+1)'(1) == num_q;
  assign empty     = ~|sr_vld[TREE_LAT-1:0];
  assign take      = sr_use[TREE_LAT] && !nan && (!seen || gt);
  assign no_result = fin && !seen;
  hdc_fp16_cmp u_cmp (.a(tree_sum), .b(out_score), .a_gt_b(gt), .a_is_nan(nan));
  // State register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // Next state; an empty run still drains one bubble token so done keeps the same latency
  always_comb
    state_nx = state == IDLE  ? (start ? (num_eff == '0 ? DRAIN : ISSUE) : IDLE) :
               state == ISSUE ? (last ? DRAIN : ISSUE) :
               state == DRAIN ? (empty ? FINISH : DRAIN) : IDLE;
  // Outputs decoded from state
  always_comb begin
    mem_rd_en = state == ISSUE;
    mem_addr  = mem_rd_en ? cnt[CLS_W-1:0] : '0;
    busy      = state != IDLE;
    done      = state == FINISH;
  end
  // Issue counter, in-flight valid/tag pipe and running argmax
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      num_q      <= '0;
      cnt        <= '0;
      sr_vld     <= '0;
      sr_use     <= '0;
      sr_tag     <= '0;
      seen       <= 1'b0;
      fin        <= 1'b0;
      out_class  <= '0;
      out_score  <= FP16_POS_ZERO;
    end else begin
      sr_vld <= {sr_vld[TREE_LAT-1:0], mem_rd_en || (state == IDLE && start && num_eff == '0)};
      sr_use <= {sr_use[TREE_LAT-1:0], mem_rd_en};
      sr_tag <= {sr_tag[TREE_LAT-1:0], mem_addr};
      cnt    <= mem_rd_en ? cnt + (CLS_W+1)'(1) : '0;
      if (state == IDLE && start) begin
        num_q     <= num_eff;
        seen      <= 1'b0;
        fin       <= 1'b0;
        out_class <= '0;
        out_score <= FP16_POS_ZERO;
      end else if (take) begin
        seen      <= 1'b1;
        out_class <= sr_tag[TREE_LAT];
        out_score <= tree_sum;
      end
      if (state == DRAIN && empty) fin <= 1'b1;
    end
endmodule
